branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-003 id_branch_i  in  1  decode presents a branch (valid).
REQ-004 id_ready_o  out  1  controller accepts branch this cycle; accept = id_branch_i & id_ready_o.
REQ-005 f3_i  in  3  branch funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
REQ-006 pc_i, imm_i, rs1_i, rs2_i  in  32 each  branch PC, sign-extended offset, operands; sampled on accept.
REQ-007 alu_req_o  out  1  request for the shared ALU.
REQ-008 alu_gnt_i  in  1  ALU granted to this block this cycle.
REQ-009 alu_op_o  out  2  00 SUB, 01 SLT, 10 SLTU.
REQ-010 alu_a_o, alu_b_o  out  32 each  latched rs1, rs2.
REQ-011 alu_result_i  in  32  ALU result; alu_valid_i  in  1  result valid.
REQ-012 flush_i  in  1  external pipeline flush.
REQ-013 branch_flag_o  out  1  resolved taken.
REQ-014 resolve_o  out  1  one-cycle pulse: branch resolved.
REQ-015 redirect_o  out  1  one-cycle pulse: fetch shall restart at redirect_pc_o.
REQ-016 redirect_pc_o  out  32  redirect target.
REQ-017 illegal_o  out  1  one-cycle pulse: f3 010 or 011 accepted.
REQ-018 pred_taken_o  out  1  prediction for current id_branch_i (combinational).

Function
REQ-019 FSM states IDLE, REQ, WAIT, RESOLVE; id_ready_o = 1 only in IDLE.
REQ-020 IDLE: on accept with legal f3 latch operands, target = pc_i + imm_i (mod 2^32), fallthrough = pc_i + 4 (mod 2^32), prediction; go REQ.
REQ-021 IDLE: on accept with illegal f3 pulse illegal_o next cycle, no ALU request, no redirect, stay IDLE.
REQ-022 REQ: alu_req_o = 1, operands/op held stable; on alu_gnt_i go WAIT; alu_gnt_i in same cycle as alu_valid_i is permitted and goes directly to RESOLVE.
REQ-023 WAIT: alu_req_o = 0; on alu_valid_i latch outcome, go RESOLVE.
REQ-024 Op select: beq/bne SUB, blt/bge SLT, bltu/bgeu SLTU.
REQ-025 Outcome: beq = (result == 0); bne = (result != 0); blt/bltu = result[0]; bge/bgeu = ~result[0].
REQ-026 RESOLVE (one cycle): resolve_o = 1, branch_flag_o = outcome; if outcome != latched prediction, redirect_o = 1, redirect_pc_o = taken ? target : fallthrough; return IDLE.
REQ-027 branch_flag_o and redirect_pc_o hold last resolved values until next RESOLVE.
REQ-028 Minimum accept-to-resolve latency 2 cycles (grant and valid in first REQ cycle); unbounded while grant withheld.
REQ-029 flush_i in REQ or WAIT: drop request, return IDLE next cycle, no resolve/redirect; late alu_valid_i is ignored.
REQ-030 flush_i in RESOLVE: resolve_o and redirect_o still issue (branch older than flush).
REQ-031 flush_i in IDLE with id_branch_i: branch not accepted.

Reset
REQ-032 rst_ni low: FSM to IDLE, all outputs 0, redirect_pc_o = 0, latched registers 0, predictor table reset per REQ-035.
REQ-033 Reset mid-operation aborts immediately; no pulse issues on release.

Configuration
REQ-034 Macro BRANCH_CTRL_BHT_EN selects dynamic prediction.
REQ-035 Defined: 16-entry table of 2-bit saturating counters indexed pc_i[5:2], reset to 01 (weakly not-taken); pred_taken_o = counter[1]; in RESOLVE the entry indexed by latched pc[5:2] increments if taken (saturate 11), else decrements (saturate 00).
REQ-036 Not defined: no table; pred_taken_o = 0; redirect_o pulses on every taken branch.

Verification
REQ-037 beq, rs1=rs2=5, grant+valid immediate, result 0 -> resolve_o 2 cycles after accept, branch_flag_o=1, redirect_o=1, redirect_pc_o = pc+imm (pc=0x100, imm=0x20 -> 0x120).
REQ-038 blt rs1=-1, rs2=1, SLT result 1, grant delayed 3 cycles -> alu_req_o held 4 cycles with stable operands, taken, redirect to target.
REQ-039 bgeu rs1=1, rs2=0xFFFFFFFF, SLTU result 1 -> not-taken, no redirect (macro undefined); pc=0xFFFFFFFC, imm=8 checks target wrap to 0x4 in latched value.
REQ-040 flush_i asserted in WAIT, then alu_valid_i -> no resolve_o/redirect_o, id_ready_o=1 next cycle.
REQ-041 f3=010 -> illegal_o pulse, alu_req_o never asserted, FSM stays IDLE.
REQ-042 With BRANCH_CTRL_BHT_EN: same taken branch at pc=0x40 three times -> redirect on 1st only; pred_taken_o=1 on 2nd and 3rd; counter saturates at 11.

Source files
------------

// File: rtl/branch_ctrl.sv
// Conditional-branch resolver: borrows the shared ALU, resolves, redirects fetch on mispredict.
// Optional 16-entry 2-bit BHT enabled by macro BRANCH_CTRL_BHT_EN; otherwise predict not-taken.
module branch_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_branch_i,
    output logic        id_ready_o,
    input  logic [2:0]  f3_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        alu_req_o,
    input  logic        alu_gnt_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_valid_i,
    input  logic        flush_i,
    output logic        branch_flag_o,
    output logic        resolve_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        illegal_o,
    output logic        pred_taken_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESOLVE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  f3_q;
    logic [31:0] a_q, b_q, target_q, fall_q, rpc_q;
    logic        pred_q, flag_q, illegal_q;
    logic        accept, f3_illegal, outcome, load_outcome;

    assign accept     = id_branch_i & id_ready_o;
    assign f3_illegal = (f3_i[2:1] == 2'b01);

    // Equality branches test for a zero difference; compare branches use bit 0 of SLT/SLTU.
    always_comb begin
        outcome = 1'b0;
        if (f3_q[2:1] == 2'b00) outcome = (alu_result_i == 32'd0) ^ f3_q[0];
        else                    outcome = alu_result_i[0] ^ f3_q[0];
    end

    always_comb begin
        alu_op_o = 2'b00;
        if (f3_q[2]) alu_op_o = f3_q[1] ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d      = state_q;
        id_ready_o   = 1'b0;
        alu_req_o    = 1'b0;
        resolve_o    = 1'b0;
        redirect_o   = 1'b0;
        load_outcome = 1'b0;
        case (state_q)
            S_IDLE: begin
                id_ready_o = rst_ni & ~flush_i;
                if (id_branch_i && !flush_i && !f3_illegal) state_d = S_REQ;
            end
            S_REQ: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    alu_req_o = 1'b1;
                    if (alu_gnt_i) begin
                        if (alu_valid_i) begin
                            state_d      = S_RESOLVE;
                            load_outcome = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (alu_valid_i) begin
                    state_d      = S_RESOLVE;
                    load_outcome = 1'b1;
                end
            end
            S_RESOLVE: begin
                // The branch is older than any flush arriving now, so it always completes.
                resolve_o  = 1'b1;
                redirect_o = (flag_q != pred_q);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            target_q  <= '0;
            fall_q    <= '0;
            pred_q    <= 1'b0;
            flag_q    <= 1'b0;
            rpc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= accept & f3_illegal;
            if (accept && !f3_illegal) begin
                f3_q     <= f3_i;
                a_q      <= rs1_i;
                b_q      <= rs2_i;
                target_q <= pc_i + imm_i;
                fall_q   <= pc_i + 32'd4;
                pred_q   <= pred_taken_o;
            end
            if (load_outcome) begin
                flag_q <= outcome;
                rpc_q  <= outcome ? target_q : fall_q;
            end
        end
    end

`ifdef BRANCH_CTRL_BHT_EN
    logic [1:0] bht_q [16];
    logic [3:0] idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) bht_q[i] <= 2'b01;
            idx_q <= '0;
        end else begin
            if (accept && !f3_illegal) idx_q <= pc_i[5:2];
            if (state_q == S_RESOLVE) begin
                if (flag_q && bht_q[idx_q] != 2'b11)       bht_q[idx_q] <= bht_q[idx_q] + 2'd1;
                else if (!flag_q && bht_q[idx_q] != 2'b00) bht_q[idx_q] <= bht_q[idx_q] - 2'd1;
            end
        end
    end

    assign pred_taken_o = bht_q[pc_i[5:2]][1];
`else
    assign pred_taken_o = 1'b0;
`endif

    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign branch_flag_o = flag_q;
    assign redirect_pc_o = rpc_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed branches, a spec-level outcome/prediction model and a per-cycle comparator.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        id_branch_i, id_ready_o;
    logic [2:0]  f3_i;
    logic [31:0] pc_i, imm_i, rs1_i, rs2_i;
    logic        alu_req_o, alu_gnt_i;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o, alu_result_i;
    logic        alu_valid_i, flush_i;
    logic        branch_flag_o, resolve_o, redirect_o, illegal_o, pred_taken_o;
    logic [31:0] redirect_pc_o;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni), .id_branch_i(id_branch_i), .id_ready_o(id_ready_o),
        .f3_i(f3_i), .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .alu_req_o(alu_req_o), .alu_gnt_i(alu_gnt_i), .alu_op_o(alu_op_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_result_i(alu_result_i),
        .alu_valid_i(alu_valid_i), .flush_i(flush_i), .branch_flag_o(branch_flag_o),
        .resolve_o(resolve_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o), .pred_taken_o(pred_taken_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic        chk_en, chk_ready, chk_ops;
    logic        exp_ready, exp_req, exp_resolve, exp_redirect, exp_illegal, exp_flag;
    logic [31:0] exp_rpc, exp_a, exp_b;
    logic [1:0]  exp_op;
    int          bht [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2:1] == 2'b00) return a - b;
        if (f3[2:1] == 2'b10) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return (a < b) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [1:0] m_op(input logic [2:0] f3);
        if (!f3[2]) return 2'b00;
        return f3[1] ? 2'b10 : 2'b01;
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
`ifdef BRANCH_CTRL_BHT_EN
        return bht[pc[5:2]] >= 2;
`else
        return (pc == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (chk_ready) check("id_ready", 32'(id_ready_o), 32'(exp_ready));
            check("alu_req",     32'(alu_req_o),     32'(exp_req));
            check("resolve",     32'(resolve_o),     32'(exp_resolve));
            check("redirect",    32'(redirect_o),    32'(exp_redirect));
            check("illegal",     32'(illegal_o),     32'(exp_illegal));
            check("branch_flag", 32'(branch_flag_o), 32'(exp_flag));
            check("redirect_pc", redirect_pc_o,      exp_rpc);
            if (chk_ops) begin
                check("alu_a",  alu_a_o,          exp_a);
                check("alu_b",  alu_b_o,          exp_b);
                check("alu_op", 32'(alu_op_o),    32'(exp_op));
            end
            if (id_branch_i) check("pred_taken", 32'(pred_taken_o), 32'(m_pred(pc_i)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gd: cycles grant is withheld; vd: cycles from grant to valid; fw: WAIT cycle to flush in (0 = none)
    task automatic do_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] a, input logic [31:0] b,
                             input int gd, input int vd, input int fw, input bit fres,
                             output int lat, output int reqc, output bit seen_pred, output bit seen_redir);
        bit          tk, pr;
        logic [31:0] res;
        tk = m_taken(f3, a, b);
        pr = m_pred(pc);
        res = m_alu(f3, a, b);
        lat = 0; reqc = 0; seen_redir = 1'b0;
        id_branch_i = 1'b1; f3_i = f3; pc_i = pc; imm_i = imm; rs1_i = a; rs2_i = b;
        exp_ready = 1'b1; exp_req = 1'b0; exp_resolve = 1'b0; exp_redirect = 1'b0;
        exp_illegal = 1'b0; chk_ops = 1'b0;
        #1 seen_pred = pred_taken_o;
        tick(); lat++;
        id_branch_i = 1'b0; rs1_i = ~a; rs2_i = ~b; f3_i = 3'b011; pc_i = 32'h0; imm_i = 32'h0;
        exp_ready = 1'b0; exp_req = 1'b1; chk_ops = 1'b1; exp_a = a; exp_b = b; exp_op = m_op(f3);
        for (int i = 0; i <= gd; i++) begin
            alu_gnt_i    = (i == gd);
            alu_valid_i  = (i == gd) && (vd == 0);
            alu_result_i = alu_valid_i ? res : 32'hDEAD_BEEF;
            reqc++;
            tick(); lat++;
        end
        alu_gnt_i = 1'b0; alu_valid_i = 1'b0; exp_req = 1'b0;
        for (int j = 1; j <= vd; j++) begin
            if (j == fw) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0; exp_ready = 1'b1; chk_ops = 1'b0;
                alu_valid_i = 1'b1; alu_result_i = res;
                tick();
                alu_valid_i = 1'b0;
                tick();
                return;
            end
            alu_valid_i  = (j == vd);
            alu_result_i = (j == vd) ? res : 32'hDEAD_BEEF;
            tick(); lat++;
        end
        alu_valid_i = 1'b0; flush_i = fres;
        exp_resolve = 1'b1; exp_redirect = (tk != pr); exp_flag = tk;
        exp_rpc = tk ? pc + imm : pc + 32'd4;
        #1 seen_redir = redirect_o;
        tick();
        flush_i = 1'b0; exp_resolve = 1'b0; exp_redirect = 1'b0; exp_ready = 1'b1; chk_ops = 1'b0;
`ifdef BRANCH_CTRL_BHT_EN
        if (tk) begin
            if (bht[pc[5:2]] < 3) bht[pc[5:2]]++;
        end else if (bht[pc[5:2]] > 0) begin
            bht[pc[5:2]]--;
        end
`endif
        tick();
    endtask

    task automatic do_illegal(input logic [2:0] f3);
        id_branch_i = 1'b1; f3_i = f3; pc_i = 32'h300; rs1_i = 32'd1; rs2_i = 32'd2;
        exp_ready = 1'b1; exp_req = 1'b0;
        tick();
        id_branch_i = 1'b0; exp_illegal = 1'b1;
        tick();
        exp_illegal = 1'b0;
        tick();
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) bht[i] = 1;
        exp_flag = 1'b0; exp_rpc = 32'h0;
    endtask

    int lat, reqc;
    bit sp, sr;

    initial begin
        rst_ni = 1'b0; id_branch_i = 1'b0; f3_i = 3'b000; pc_i = '0; imm_i = '0; rs1_i = '0; rs2_i = '0;
        alu_gnt_i = 1'b0; alu_valid_i = 1'b0; alu_result_i = '0; flush_i = 1'b0;
        chk_en = 1'b1; chk_ready = 1'b1; chk_ops = 1'b1;
        exp_ready = 1'b0; exp_req = 1'b0; exp_resolve = 1'b0; exp_redirect = 1'b0; exp_illegal = 1'b0;
        exp_a = '0; exp_b = '0; exp_op = 2'b00;
        reset_model();
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_ni = 1'b1; exp_ready = 1'b1; chk_ops = 1'b0;
        tick();

        // beq 5==5, immediate grant+valid
        do_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0, 0, 0, 1'b0, lat, reqc, sp, sr);
        check("beq_latency", 32'(lat), 32'd2);
        check("beq_target", redirect_pc_o, 32'h120);
        check("beq_flag", 32'(branch_flag_o), 32'd1);
        check("beq_redirect", 32'(sr), 32'd1);

        // blt -1 < 1, grant withheld 3 cycles
        do_branch(3'b100, 32'h204, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 3, 0, 0, 1'b0, lat, reqc, sp, sr);
        check("blt_req_cycles", 32'(reqc), 32'd4);
        check("blt_latency", 32'(lat), 32'd5);
        check("blt_target", redirect_pc_o, 32'h1F4);
        check("blt_redirect", 32'(sr), 32'd1);

        // bgeu 1 >= 0xFFFFFFFF is false; fallthrough wraps to 0
        do_branch(3'b111, 32'hFFFF_FFFC, 32'd8, 32'd1, 32'hFFFF_FFFF, 0, 2, 0, 1'b0, lat, reqc, sp, sr);
        check("bgeu_flag", 32'(branch_flag_o), 32'd0);
        check("bgeu_redirect", 32'(sr), 32'd0);
        check("bgeu_fallthrough", redirect_pc_o, 32'h0);
        do_branch(3'b000, 32'hFFFF_FFFC, 32'd8, 32'd7, 32'd7, 1, 1, 0, 1'b0, lat, reqc, sp, sr);
        check("wrap_target", redirect_pc_o, 32'h4);

        // Remaining f3 encodings, taken and not-taken
        do_branch(3'b001, 32'h408, 32'h10,        32'd3,          32'd4,          0, 1, 0, 1'b0, lat, reqc, sp, sr);
        do_branch(3'b001, 32'h40C, 32'h10,        32'd9,          32'd9,          2, 0, 0, 1'b0, lat, reqc, sp, sr);
        do_branch(3'b101, 32'h410, 32'hFFFF_FF00, 32'hFFFF_FFFB,  32'hFFFF_FFFB,  0, 0, 0, 1'b0, lat, reqc, sp, sr);
        do_branch(3'b101, 32'h414, 32'h40,        32'd1,          32'hFFFF_FFFF,  1, 0, 0, 1'b0, lat, reqc, sp, sr);
        do_branch(3'b100, 32'h418, 32'h40,        32'd2,          32'hFFFF_FFFD,  0, 0, 0, 1'b0, lat, reqc, sp, sr);
        do_branch(3'b110, 32'h41C, 32'h80,        32'd1,          32'd2,          0, 3, 0, 1'b0, lat, reqc, sp, sr);
        do_branch(3'b110, 32'h420, 32'h80,        32'hFFFF_FFFF,  32'd1,          0, 0, 0, 1'b0, lat, reqc, sp, sr);
        check("bltu_notaken_flag", 32'(branch_flag_o), 32'd0);
        check("bltu_notaken_pc", redirect_pc_o, 32'h424);

        // Flush during RESOLVE still resolves
        do_branch(3'b000, 32'h440, 32'h100, 32'd0, 32'd0, 0, 0, 0, 1'b1, lat, reqc, sp, sr);
        check("flush_resolve_redirect", 32'(sr), 32'd1);

        // Flush during WAIT, late valid ignored
        do_branch(3'b000, 32'h480, 32'h200, 32'd6, 32'd6, 0, 3, 1, 1'b0, lat, reqc, sp, sr);
        check("flush_wait_keeps_pc", redirect_pc_o, 32'h540);

        // Flush in IDLE with a branch present: not accepted
        id_branch_i = 1'b1; f3_i = 3'b000; pc_i = 32'h500; rs1_i = '0; rs2_i = '0; flush_i = 1'b1;
        chk_ready = 1'b0;
        tick();
        chk_ready = 1'b1; flush_i = 1'b0; id_branch_i = 1'b0; exp_ready = 1'b1; exp_req = 1'b0;
        tick();
        tick();

        do_illegal(3'b010);
        do_illegal(3'b011);

        // Reset in the middle of a request
        id_branch_i = 1'b1; f3_i = 3'b000; pc_i = 32'h80; imm_i = 32'h8; rs1_i = 32'd1; rs2_i = 32'd1;
        exp_ready = 1'b1;
        tick();
        id_branch_i = 1'b0; exp_ready = 1'b0; exp_req = 1'b1;
        chk_ops = 1'b1; exp_a = 32'd1; exp_b = 32'd1; exp_op = 2'b00;
        @(negedge clk); #1 rst_ni = 1'b0;
        exp_req = 1'b0; exp_a = '0; exp_b = '0;
        reset_model();
        @(negedge clk);
        @(posedge clk); #1 rst_ni = 1'b1;
        exp_ready = 1'b1; chk_ops = 1'b0;
        alu_gnt_i = 1'b1; alu_valid_i = 1'b1; alu_result_i = '0;
        tick();
        alu_gnt_i = 1'b0; alu_valid_i = 1'b0;
        tick();

        // Same branch PC repeatedly: taken x3, not-taken, taken
        do_branch(3'b000, 32'h40, 32'h60, 32'd2, 32'd2, 0, 0, 0, 1'b0, lat, reqc, sp, sr);
        check("bht_run1_pred", 32'(sp), 32'd0);
        check("bht_run1_redirect", 32'(sr), 32'd1);
        do_branch(3'b000, 32'h40, 32'h60, 32'd2, 32'd2, 0, 0, 0, 1'b0, lat, reqc, sp, sr);
`ifdef BRANCH_CTRL_BHT_EN
        check("bht_run2_pred", 32'(sp), 32'd1);
        check("bht_run2_redirect", 32'(sr), 32'd0);
`else
        check("run2_pred", 32'(sp), 32'd0);
        check("run2_redirect", 32'(sr), 32'd1);
`endif
        do_branch(3'b000, 32'h40, 32'h60, 32'd2, 32'd2, 0, 0, 0, 1'b0, lat, reqc, sp, sr);
`ifdef BRANCH_CTRL_BHT_EN
        check("bht_run3_pred", 32'(sp), 32'd1);
        check("bht_run3_redirect", 32'(sr), 32'd0);
`else
        check("run3_redirect", 32'(sr), 32'd1);
`endif
        do_branch(3'b000, 32'h40, 32'h60, 32'd1, 32'd2, 0, 0, 0, 1'b0, lat, reqc, sp, sr);
`ifdef BRANCH_CTRL_BHT_EN
        check("bht_run4_pred", 32'(sp), 32'd1);
        check("bht_run4_redirect", 32'(sr), 32'd1);
        check("bht_run4_pc", redirect_pc_o, 32'h44);
`else
        check("run4_redirect", 32'(sr), 32'd0);
`endif
        do_branch(3'b000, 32'h40, 32'h60, 32'd3, 32'd3, 0, 0, 0, 1'b0, lat, reqc, sp, sr);
`ifdef BRANCH_CTRL_BHT_EN
        check("bht_run5_pred", 32'(sp), 32'd1);
`else
        check("run5_pred", 32'(sp), 32'd0);
`endif
        check("run5_target", redirect_pc_o, 32'hA0);

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
